// File: rtl/ax_btb_updater_pkg.sv
// Shared fetch-unit types for the approximate-branch BTB (AXBTB) write path.
// Holds the update record layout and the PC-to-index/tag slicing helper.
package FetchUnitTypes;

  localparam int AX_BTB_ENTRY_NUM   = 128;
  localparam int AX_BTB_INDEX_WIDTH = 7;
  localparam int AX_BTB_TAG_WIDTH   = 8;
  localparam int AX_BTB_PC_WIDTH    = 32;

  typedef logic [AX_BTB_INDEX_WIDTH-1:0] AxBtbIndexPath;
  typedef logic [AX_BTB_TAG_WIDTH-1:0]   AxBtbTagPath;
  typedef logic [AX_BTB_PC_WIDTH-1:0]    AxBtbPcPath;

  typedef struct packed {
    AxBtbIndexPath index;
    AxBtbTagPath   tag;
    AxBtbPcPath    target;
  } AxBtbUpdateReq;

  // Instructions are word aligned, so the index starts at PC bit 2 and the tag follows it.
  function automatic AxBtbUpdateReq make_update_req(input AxBtbPcPath pc,
                                                    input AxBtbPcPath target);
    AxBtbUpdateReq req;
    req.index  = pc[AX_BTB_INDEX_WIDTH+1:2];
    req.tag    = pc[AX_BTB_INDEX_WIDTH+2 +: AX_BTB_TAG_WIDTH];
    req.target = target;
    return req;
  endfunction

endpackage

// File: rtl/ax_btb_update_queue.sv
// Small FIFO of pending AXBTB updates. A push that hits the same index as the
// newest queued entry overwrites it in place instead of taking a new slot.
module ax_btb_update_queue
  import FetchUnitTypes::*;
#(
  parameter int QUEUE_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  AxBtbUpdateReq push_data,
  input  logic          pop,
  output AxBtbUpdateReq head,
  output logic          empty,
  output logic          full
);

  localparam int PTR_WIDTH = $clog2(QUEUE_DEPTH);

  typedef logic [PTR_WIDTH:0] ptr_t;

  AxBtbUpdateReq        slots [QUEUE_DEPTH];
  ptr_t                 rd_ptr;
  ptr_t                 wr_ptr;
  ptr_t                 tail_ptr;
  ptr_t                 occupancy;
  logic [PTR_WIDTH-1:0] tail_slot;
  logic                 tail_popped;
  logic                 coalesce;
  logic                 append;

  assign empty     = (rd_ptr == wr_ptr);
  assign full      = (rd_ptr[PTR_WIDTH] != wr_ptr[PTR_WIDTH]) &&
                     (rd_ptr[PTR_WIDTH-1:0] == wr_ptr[PTR_WIDTH-1:0]);
  assign head      = slots[rd_ptr[PTR_WIDTH-1:0]];
  assign tail_ptr  = wr_ptr - ptr_t'(1);
  assign tail_slot = tail_ptr[PTR_WIDTH-1:0];
  assign occupancy = wr_ptr - rd_ptr;

  // When the only entry is leaving this cycle it must issue unmodified, so the push gets its own slot.
  assign tail_popped = pop && (occupancy == ptr_t'(1));
  assign coalesce    = push && !empty && !tail_popped &&
                       (slots[tail_slot].index == push_data.index);
  assign append      = push && !coalesce && !full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + ptr_t'(1);
      end
      if (append) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      if (coalesce) begin
        slots[tail_slot] <= push_data;
      end else if (append) begin
        slots[wr_ptr[PTR_WIDTH-1:0]] <= push_data;
      end
    end
  end

endmodule

// File: rtl/ax_btb_updater.sv
// Write side of the approximate-branch BTB: installs committed branch records and
// sweeps the whole table invalid after reset or fence.i, yielding to fetch reads.
module ax_btb_updater
  import FetchUnitTypes::*;
#(
  parameter int ENTRY_NUM   = AX_BTB_ENTRY_NUM,
  parameter int INDEX_WIDTH = AX_BTB_INDEX_WIDTH,
  parameter int TAG_WIDTH   = AX_BTB_TAG_WIDTH,
  parameter int PC_WIDTH    = AX_BTB_PC_WIDTH,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   brValid,
  input  logic [PC_WIDTH-1:0]    brPC,
  input  logic [PC_WIDTH-1:0]    brTarget,
  output logic                   brReady,
  input  logic                   flushReq,
  output logic                   flushBusy,
  input  logic                   fetchRdEn,
  input  logic [INDEX_WIDTH-1:0] fetchRdIndex,
  output logic                   wrEn,
  output logic [INDEX_WIDTH-1:0] wrIndex,
  output logic [TAG_WIDTH-1:0]   wrTag,
  output logic [PC_WIDTH-1:0]    wrTarget,
  output logic                   wrValid
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  localparam AxBtbIndexPath LAST_INDEX = AxBtbIndexPath'(ENTRY_NUM - 1);

  logic [0:0]    state;
  logic [0:0]    state_next;
  AxBtbIndexPath sweep_idx;
  AxBtbIndexPath sweep_next;

  AxBtbUpdateReq incoming;
  AxBtbUpdateReq head;
  AxBtbUpdateReq candidate;
  AxBtbUpdateReq wr_req_next;
  logic          q_empty;
  logic          q_full;
  logic          q_push;
  logic          q_pop;
  logic          push_accept;
  logic          cand_valid;
  logic          blocked;
  logic          wr_en_next;
  logic          wr_valid_next;

  assign incoming    = make_update_req(brPC, brTarget);
  assign brReady     = (state == ST_IDLE) && !q_full;
  assign flushBusy   = (state == ST_FLUSH);
  assign push_accept = brValid && brReady && !flushReq;

  ax_btb_update_queue #(
    .QUEUE_DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .clear    (flushReq),
    .push     (q_push),
    .push_data(incoming),
    .pop      (q_pop),
    .head     (head),
    .empty    (q_empty),
    .full     (q_full)
  );

  // An empty queue lets an accepted push go straight to the write port, so it lands one cycle later.
  always_comb begin
    state_next    = state;
    sweep_next    = sweep_idx;
    candidate     = head;
    cand_valid    = 1'b0;
    blocked       = 1'b0;
    q_push        = push_accept;
    q_pop         = 1'b0;
    wr_en_next    = 1'b0;
    wr_valid_next = 1'b0;
    wr_req_next   = '0;

    if (flushReq) begin
      state_next = ST_FLUSH;
      sweep_next = '0;
      q_push     = 1'b0;
    end else if (state == ST_FLUSH) begin
      blocked = fetchRdEn && (fetchRdIndex == sweep_idx);
      if (!blocked) begin
        wr_en_next        = 1'b1;
        wr_req_next.index = sweep_idx;
        sweep_next        = sweep_idx + AxBtbIndexPath'(1);
        if (sweep_idx == LAST_INDEX) begin
          state_next = ST_IDLE;
        end
      end
    end else begin
      if (!q_empty) begin
        candidate  = head;
        cand_valid = 1'b1;
      end else if (push_accept) begin
        candidate  = incoming;
        cand_valid = 1'b1;
      end
      blocked = fetchRdEn && (fetchRdIndex == candidate.index);
      if (cand_valid && !blocked) begin
        wr_en_next    = 1'b1;
        wr_valid_next = 1'b1;
        wr_req_next   = candidate;
        if (q_empty) begin
          q_push = 1'b0;
        end else begin
          q_pop = 1'b1;
        end
      end
    end
  end

  // Write fields keep their last value on idle cycles; only wrEn says whether they mean anything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_FLUSH;
      sweep_idx <= '0;
      wrEn      <= 1'b0;
      wrIndex   <= '0;
      wrTag     <= '0;
      wrTarget  <= '0;
      wrValid   <= 1'b0;
    end else begin
      state     <= state_next;
      sweep_idx <= sweep_next;
      wrEn      <= wr_en_next;
      if (wr_en_next) begin
        wrIndex  <= wr_req_next.index;
        wrTag    <= wr_req_next.tag;
        wrTarget <= wr_req_next.target;
        wrValid  <= wr_valid_next;
      end
    end
  end

endmodule

// File: tb/tb_ax_btb_updater.sv
// Bench for ax_btb_updater: directed scenarios then random traffic, each cycle
// compared against a queue-based model of the update/invalidate rules.
module tb_ax_btb_updater;

  localparam int DEPTH   = 4;
  localparam int ENTRIES = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        brValid = 1'b0;
  logic [31:0] brPC = '0;
  logic [31:0] brTarget = '0;
  logic        brReady;
  logic        flushReq = 1'b0;
  logic        flushBusy;
  logic        fetchRdEn = 1'b0;
  logic [6:0]  fetchRdIndex = '0;
  logic        wrEn;
  logic [6:0]  wrIndex;
  logic [7:0]  wrTag;
  logic [31:0] wrTarget;
  logic        wrValid;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          idx;
    int          tag;
    logic [31:0] tgt;
  } rec_t;

  rec_t        q[$];
  bit          m_flushing;
  int          m_count;
  bit          e_wrEn;
  bit          e_valid;
  int          e_idx;
  int          e_tag;
  logic [31:0] e_tgt;

  ax_btb_updater dut (
    .clk         (clk),
    .rst         (rst),
    .brValid     (brValid),
    .brPC        (brPC),
    .brTarget    (brTarget),
    .brReady     (brReady),
    .flushReq    (flushReq),
    .flushBusy   (flushBusy),
    .fetchRdEn   (fetchRdEn),
    .fetchRdIndex(fetchRdIndex),
    .wrEn        (wrEn),
    .wrIndex     (wrIndex),
    .wrTag       (wrTag),
    .wrTarget    (wrTarget),
    .wrValid     (wrValid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_flushing = 1'b1;
    m_count    = 0;
  endtask

  task automatic check_reset_state();
    check("rst_wrEn", wrEn, 0);
    check("rst_wrIndex", wrIndex, 0);
    check("rst_wrTag", wrTag, 0);
    check("rst_wrTarget", wrTarget, 0);
    check("rst_wrValid", wrValid, 0);
    check("rst_flushBusy", flushBusy, 1);
    check("rst_brReady", brReady, 0);
  endtask

  // One clock: check combinational outputs, advance the model, then check the registered write.
  task automatic tick();
    bit   ready;
    bit   push;
    bit   popped;
    rec_t r;
    #1;
    ready = !m_flushing && (q.size() < DEPTH);
    check("brReady", brReady, ready);
    check("flushBusy", flushBusy, m_flushing);

    e_wrEn = 1'b0;
    push   = brValid && ready;
    r.idx  = (brPC >> 2) % 128;
    r.tag  = (brPC >> 9) % 256;
    r.tgt  = brTarget;
    if (flushReq) begin
      m_flushing = 1'b1;
      m_count    = 0;
      q.delete();
    end else if (m_flushing) begin
      if (!(fetchRdEn && fetchRdIndex == m_count)) begin
        e_wrEn  = 1'b1;
        e_valid = 1'b0;
        e_idx   = m_count;
        m_count++;
        if (m_count == ENTRIES) begin
          m_flushing = 1'b0;
          m_count    = 0;
        end
      end
    end else if (q.size() == 0) begin
      if (push) begin
        if (fetchRdEn && fetchRdIndex == r.idx) begin
          q.push_back(r);
        end else begin
          e_wrEn  = 1'b1;
          e_valid = 1'b1;
          e_idx   = r.idx;
          e_tag   = r.tag;
          e_tgt   = r.tgt;
        end
      end
    end else begin
      popped = !(fetchRdEn && fetchRdIndex == q[0].idx);
      if (popped) begin
        e_wrEn  = 1'b1;
        e_valid = 1'b1;
        e_idx   = q[0].idx;
        e_tag   = q[0].tag;
        e_tgt   = q[0].tgt;
      end
      if (push) begin
        if (q[q.size()-1].idx == r.idx && !(popped && q.size() == 1))
          q[q.size()-1] = r;
        else
          q.push_back(r);
      end
      if (popped) void'(q.pop_front());
    end

    @(posedge clk);
    #1;
    check("wrEn", wrEn, e_wrEn);
    if (e_wrEn) begin
      check("wrIndex", wrIndex, e_idx);
      check("wrValid", wrValid, e_valid);
      if (e_valid) begin
        check("wrTag", wrTag, e_tag);
        check("wrTarget", wrTarget, e_tgt);
      end
    end
  endtask

  task automatic push_one(input logic [31:0] pc, input logic [31:0] tgt);
    brValid  = 1'b1;
    brPC     = pc;
    brTarget = tgt;
    tick();
    brValid  = 1'b0;
  endtask

  initial begin
    logic [31:0] pcs [4];
    pcs[0] = 32'h0;
    pcs[1] = 32'h10;
    pcs[2] = 32'h20;
    pcs[3] = 32'h30;

    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    rst = 1'b1;
    model_reset();

    $display("[TB] power-up invalidation sweep");
    repeat (ENTRIES) tick();
    tick();

    $display("[TB] single update, then fetch-blocked update");
    push_one(32'h0000_1004, 32'h2000);
    tick();
    fetchRdEn    = 1'b1;
    fetchRdIndex = 7'd1;
    push_one(32'h0000_1004, 32'h2100);
    repeat (2) tick();
    fetchRdEn = 1'b0;
    repeat (2) tick();

    $display("[TB] fill queue behind a blocked head");
    fetchRdEn    = 1'b1;
    fetchRdIndex = 7'd0;
    for (int i = 0; i < 4; i++) push_one(pcs[i], 32'h4000 + i);
    tick();
    fetchRdEn = 1'b0;
    repeat (5) tick();

    $display("[TB] coalesce two updates to one index");
    fetchRdEn    = 1'b1;
    fetchRdIndex = 7'd1;
    push_one(32'h0000_1004, 32'h2000);
    push_one(32'h0000_1004, 32'h3000);
    tick();
    fetchRdEn = 1'b0;
    repeat (3) tick();

    $display("[TB] flush beats push, flush restart mid-sweep");
    flushReq = 1'b1;
    push_one(32'h0000_0040, 32'h5000);
    flushReq = 1'b0;
    repeat (50) tick();
    flushReq = 1'b1;
    tick();
    flushReq = 1'b0;
    repeat (ENTRIES + 1) tick();

    $display("[TB] random traffic");
    for (int c = 0; c < 1200; c++) begin
      if (c == 600) begin
        rst = 1'b0;
        #1;
        check_reset_state();
        rst = 1'b1;
        model_reset();
      end
      brValid      = ($urandom_range(0, 1) == 1);
      brPC         = ($urandom & 32'hFFFF_FE00) | (32'($urandom_range(0, 7)) << 2);
      brTarget     = $urandom;
      fetchRdEn    = ($urandom_range(0, 9) < 3);
      fetchRdIndex = 7'($urandom_range(0, 7));
      flushReq     = ($urandom_range(0, 199) == 0);
      tick();
    end
    brValid   = 1'b0;
    fetchRdEn = 1'b0;
    flushReq  = 1'b0;
    repeat (ENTRIES + 8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
